button_conditioner: RTL

Multi-channel push-button front end that replaces the single-button edge/lockout handler. It gives each channel a two-flop synchroniser, a counter debounce, a one-cycle press pulse with a per-channel lockout window, a release pulse, and an optional hold-to-repeat mode. It sits between the board push-buttons and the game control FSM, which consumes only single-cycle `PRESS` and `RELEASE` pulses.

---
 rtl/button_conditioner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Each channel has a two-flop synchroniser, a counter debounce, a lockout-gated
// press pulse with optional hold-to-repeat, and a release pulse.
module button_conditioner #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LOCKOUT_CYCLES  = 30000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] IN,
    input  logic [CHANNELS-1:0] REPEAT_EN,
    output logic [CHANNELS-1:0] LEVEL,
    output logic [CHANNELS-1:0] PRESS,
    output logic [CHANNELS-1:0] RELEASE
);

    // Counter widths; the lockout counter keeps one bit even when lockout is disabled.
    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LW   = (LOCKOUT_CYCLES == 0) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          s1;
        logic          s2;
        logic [DW-1:0] db_cnt;
        logic          level;
        logic [LW-1:0] lk;
        logic [RW-1:0] rc;
        state_t        state;
        logic          press;
        logic          rel;

        logic          db_hit_c;
        logic          rise_c;
        logic          fall_c;
        logic          accept_c;

        // Two-flop synchroniser for the raw asynchronous button level.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= IN[i];
                s2 <= s1;
            end
        end

        // Edge events that the debounce register will commit on this clock edge.
        always_comb begin
            db_hit_c = 1'b0;
            rise_c   = 1'b0;
            fall_c   = 1'b0;
            accept_c = 1'b0;
            if ((s2 != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1))) begin
                db_hit_c = 1'b1;
            end
            rise_c   = db_hit_c && !level;
            fall_c   = db_hit_c && level;
            accept_c = rise_c && (lk == '0);
        end

        // Debounce: level follows s2 only after it has differed for the full count.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                db_cnt <= '0;
                level  <= 1'b0;
            end else if (s2 == level) begin
                db_cnt <= '0;
            end else if (db_hit_c) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end

        // Lockout window: reloaded by accepted fresh presses only, never by repeats.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                lk <= '0;
            end else if (accept_c) begin
                lk <= LW'(LOCKOUT_CYCLES);
            end else if (lk != '0) begin
                lk <= lk - LW'(1);
            end
        end

        // Press/repeat/release FSM; a debounced fall outranks any repeat terminal count.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state <= IDLE;
                rc    <= '0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                if (fall_c) begin
                    state <= IDLE;
                    rc    <= '0;
                    rel   <= 1'b1;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rise_c) begin
                                rc <= '0;
                                if (accept_c) begin
                                    press <= 1'b1;
                                    state <= REPEAT_EN[i] ? DELAY : HOLD;
                                end else begin
                                    state <= HOLD;
                                end
                            end
                        end
                        DELAY: begin
                            if (!REPEAT_EN[i]) begin
                                state <= HOLD;
                                rc    <= '0;
                            end else if (rc == RW'(REPEAT_DELAY - 1)) begin
                                press <= 1'b1;
                                rc    <= '0;
                                state <= REPEAT;
                            end else begin
                                rc <= rc + RW'(1);
                            end
                        end
                        REPEAT: begin
                            if (!REPEAT_EN[i]) begin
                                state <= HOLD;
                                rc    <= '0;
                            end else if (rc == RW'(REPEAT_PERIOD - 1)) begin
                                press <= 1'b1;
                                rc    <= '0;
                            end else begin
                                rc <= rc + RW'(1);
                            end
                        end
                        HOLD: begin
                            state <= HOLD;
                        end
                        default: begin
                            state <= IDLE;
                            rc    <= '0;
                        end
                    endcase
                end
            end
        end

        assign LEVEL[i]   = level;
        assign PRESS[i]   = press;
        assign RELEASE[i] = rel;
    end

endmodule
